lcd_pixel_source: RTL

//  Raster pixel generator for the 160x80 PMOD LCD, upstream of spi_lcd_controller.
//  On a frame_start pulse it streams one frame of RGB565 pixels in raster order over a valid/ready handshake.
//  spi_lcd_controller pulls one pixel per 16 SCK bits during its memory-write phase.

---
 rtl/lcd_pixel_source.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lcd_pixel_source.sv
// Raster pixel generator for the 160x80 PMOD LCD: streams one RGB565 frame per
// frame_start over a valid/ready handshake, with four selectable test patterns.
module lcd_pixel_source #(
    parameter int H_RES = 160,
    parameter int V_RES = 80,
    parameter int BAR_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [1:0]  pattern_sel,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        pix_last,
    output logic [7:0]  h_pos,
    output logic [6:0]  v_pos,
    output logic [7:0]  frame_cnt,
    output logic        busy
);

    // Handshake: a pixel transfers on any clock edge where pix_valid && pix_ready;
    // pix_valid never drops mid-frame and all pixel outputs hold while stalled.

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] H_LAST = 8'(H_RES - 1);
    localparam logic [6:0] V_LAST = 7'(V_RES - 1);

    state_t      state_q, state_d;
    logic [7:0]  h_q, h_d;
    logic [6:0]  v_q, v_d;
    logic [1:0]  pat_q, pat_d;
    logic [7:0]  fstart_q, fstart_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic        last_q, last_d;
    logic [7:0]  nh;
    logic [6:0]  nv;

    function automatic logic [15:0] pixel_fn(input logic [7:0] h, input logic [6:0] v,
                                             input logic [1:0] pat, input logic [7:0] f);
        logic [2:0]  idx;
        logic [15:0] px;
        idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (int'(h) >= i * BAR_W) idx = 3'(i);
        end
        px = '0;
        case (pat)
            2'd0: begin
                case (idx)
                    3'd0:    px = 16'hFFFF;
                    3'd1:    px = 16'hFFE0;
                    3'd2:    px = 16'h07FF;
                    3'd3:    px = 16'h07E0;
                    3'd4:    px = 16'hF81F;
                    3'd5:    px = 16'hF800;
                    3'd6:    px = 16'h001F;
                    default: px = 16'h0000;
                endcase
            end
            2'd1:    px = (h[3] ^ v[3]) ? 16'hFFFF : 16'h0000;
            2'd2:    px = {h[7:3], v[6:1], f[4:0]};
            default: px = {f[7:3], f[7:2], f[7:3]};
        endcase
        return px;
    endfunction

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        pat_d    = pat_q;
        fstart_d = fstart_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        last_d   = last_q;
        nh       = '0;
        nv       = '0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = RUN;
                    pat_d    = pattern_sel;
                    fstart_d = cnt_q;
                    h_d      = '0;
                    v_d      = '0;
                    data_d   = pixel_fn(8'd0, 7'd0, pattern_sel, cnt_q);
                    last_d   = 1'b0;
                end
            end
            default: begin
                if (pix_ready) begin
                    if (last_q) begin
                        // Frame done: clear pixel outputs so IDLE looks like reset.
                        state_d = IDLE;
                        cnt_d   = cnt_q + 8'd1;
                        h_d     = '0;
                        v_d     = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        if (h_q == H_LAST) begin
                            nh = '0;
                            nv = v_q + 7'd1;
                        end else begin
                            nh = h_q + 8'd1;
                            nv = v_q;
                        end
                        h_d    = nh;
                        v_d    = nv;
                        data_d = pixel_fn(nh, nv, pat_q, fstart_q);
                        last_d = (nh == H_LAST) && (nv == V_LAST);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            h_q      <= '0;
            v_q      <= '0;
            pat_q    <= '0;
            fstart_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            pat_q    <= pat_d;
            fstart_q <= fstart_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    assign pix_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign pix_data  = data_q;
    assign pix_last  = last_q;
    assign h_pos     = h_q;
    assign v_pos     = v_q;
    assign frame_cnt = cnt_q;

endmodule
